bracket_matcher: RTL

Downstream of the program loader. Once `loaded` asserts, it scans program memory from address 0 to PROG_LEN, pairs every `[` with its `]` using a LIFO, and writes a jump table that the execution core uses for single-cycle loop branches. It reports completion, or the first structural error, and then holds.

---
 rtl/bf_pkg.sv | 25 ++
 rtl/bracket_matcher_if.sv | 43 ++++
 rtl/bm_stack.sv | 47 ++++
 rtl/bracket_matcher.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared opcode constants and enums for the loop-bracket matcher.
// Imported by the execution core as well as by this block.
package bf_pkg;

  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;

  typedef enum logic [1:0] {
    ERR_NONE            = 2'd0,
    ERR_UNMATCHED_CLOSE = 2'd1,
    ERR_UNMATCHED_OPEN  = 2'd2,
    ERR_OVERFLOW        = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_WRITE2,
    S_FINISH,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/bracket_matcher_if.sv
// Program-memory read port, jump-table write port and scan status.
// master = bracket_matcher, slave = loader/memories/core side.
interface bracket_matcher_if
  import bf_pkg::*;
#(
  parameter int AW = 12
);

  logic          loaded;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_rd;
  logic          jt_we;
  logic [AW-1:0] jt_addr;
  logic [AW-1:0] jt_wr;
  logic          done;
  logic          error;
  err_code_t     error_code;

  modport master (
    input  loaded,
    input  prog_rd,
    output prog_addr,
    output jt_we,
    output jt_addr,
    output jt_wr,
    output done,
    output error,
    output error_code
  );

  modport slave (
    output loaded,
    output prog_rd,
    input  prog_addr,
    input  jt_we,
    input  jt_addr,
    input  jt_wr,
    input  done,
    input  error,
    input  error_code
  );

endinterface

// File: rtl/bm_stack.sv
// LIFO of open-bracket addresses; reset clears the pointer only.
// top is valid combinationally so a pop can consume it in the same cycle.
module bm_stack #(
  parameter int DEPTH = 64,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = IW'(sp_q);
  assign rd_idx = IW'(sp_q - PW'(1));
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == PW'(DEPTH));
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/bracket_matcher.sv
// Scans program memory once after load, pairs [ with ] and writes
// both directions of each pair into the jump table.
module bracket_matcher
  import bf_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH = 12,
  parameter int PROG_LEN        = 4095,
  parameter int STACK_DEPTH     = 64
) (
  input logic               clk,
  input logic               reset,
  bracket_matcher_if.master bus
);

  localparam int AW = PROG_ADDR_WIDTH;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] o_q, o_d;
  err_code_t     err_q, err_d;

  logic          push, pop;
  logic          empty, full;
  logic [AW-1:0] top;
  logic          adv;
  logic          last;
  logic          is_open, is_close;
  logic          jt_we;
  logic [AW-1:0] jt_addr, jt_wr;

  assign last     = (pc_q == AW'(PROG_LEN));
  assign is_open  = (bus.prog_rd == OP_LOOP_OPEN);
  assign is_close = (bus.prog_rd == OP_LOOP_CLOSE);

  bm_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (AW)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q),
    .top   (top),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      o_q     <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      o_q     <= o_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    o_d     = o_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    adv     = 1'b0;
    jt_we   = 1'b0;
    jt_addr = '0;
    jt_wr   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.loaded) begin
          pc_d    = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        unique case (1'b1)
          is_open: begin
            if (full) begin
              err_d   = ERR_OVERFLOW;
              state_d = S_ERROR;
            end else begin
              push = 1'b1;
              adv  = 1'b1;
            end
          end
          is_close: begin
            if (empty) begin
              err_d   = ERR_UNMATCHED_CLOSE;
              state_d = S_ERROR;
            end else begin
              pop     = 1'b1;
              jt_we   = 1'b1;
              jt_addr = pc_q;
              jt_wr   = top;
              o_d     = top;
              state_d = S_WRITE2;
            end
          end
          default: adv = 1'b1;
        endcase
      end
      S_WRITE2: begin
        jt_we   = 1'b1;
        jt_addr = o_q;
        jt_wr   = pc_q;
        adv     = 1'b1;
      end
      S_FINISH: begin
        if (empty) begin
          state_d = S_DONE;
        end else begin
          err_d   = ERR_UNMATCHED_OPEN;
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // pc stops at the last address instead of wrapping
    if (adv) begin
      if (last) begin
        state_d = S_FINISH;
      end else begin
        pc_d    = pc_q + AW'(1);
        state_d = S_READ;
      end
    end
  end

  assign bus.prog_addr  = pc_q;
  assign bus.jt_we      = jt_we;
  assign bus.jt_addr    = jt_addr;
  assign bus.jt_wr      = jt_wr;
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_ERROR);
  assign bus.error_code = err_q;

endmodule
